// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU memory-port arbiter: read owners, arbiter states and read tags.
package cpu_mem_pkg;

    typedef enum logic {OWN_IF, OWN_LS} owner_e;

    typedef enum logic [1:0] {ARB, LOCK_IF, LOCK_LS} arb_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } rd_tag_t;

    localparam int unsigned TAG_W    = $bits(rd_tag_t);
    // Wide enough for the largest supported streak limit (15).
    localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-latency shift register of read tags; the output stage names the owner of the
// read data arriving from memory this cycle.
module rd_tag_pipe
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out
);

    rd_tag_t pipe_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '{valid: 1'b0, owner: OWN_IF};
            end
        end else begin
            pipe_q[0] <= rd_tag_t'(tag_in);
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store. Load/store wins
// arbitration until its streak limit is hit while fetch waits; stalled commands are locked.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned READ_LATENCY    = 1,
    parameter int unsigned MAX_LDST_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_if_rd,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_waitrequest,
    output logic [DATA_W-1:0] o_if_rddata,
    output logic              o_if_rddatavalid,
    input  logic              i_ls_rd,
    input  logic              i_ls_wr,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wrdata,
    output logic              o_ls_waitrequest,
    output logic [DATA_W-1:0] o_ls_rddata,
    output logic              o_ls_rddatavalid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_wrdata,
    input  logic              i_mem_waitrequest,
    input  logic [DATA_W-1:0] i_mem_rddata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LDST_STREAK);

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                ls_req, if_pick, ls_pick, accept, rd_accept;
    rd_tag_t             tag_in, tag_out;
    logic [DATA_W-1:0]   if_data_q, ls_data_q;

    assign ls_req = i_ls_rd | i_ls_wr;

    always_comb begin
        state_d = state_q;
        if_pick = 1'b0;
        ls_pick = 1'b0;
        unique case (state_q)
            ARB: begin
                if (i_if_rd && (!ls_req || streak_q == STREAK_MAX)) begin
                    if_pick = 1'b1;
                end else if (ls_req) begin
                    ls_pick = 1'b1;
                end
                if (i_mem_waitrequest && if_pick) begin
                    state_d = LOCK_IF;
                end else if (i_mem_waitrequest && ls_pick) begin
                    state_d = LOCK_LS;
                end
            end
            LOCK_IF: begin
                if_pick = 1'b1;
                if (!i_mem_waitrequest) state_d = ARB;
            end
            LOCK_LS: begin
                ls_pick = 1'b1;
                if (!i_mem_waitrequest) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
        // Grants are suppressed while reset is held so the memory sees no command.
        if (reset) begin
            if_pick = 1'b0;
            ls_pick = 1'b0;
        end
    end

    always_comb begin
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_addr   = '0;
        o_mem_wrdata = '0;
        if (if_pick) begin
            o_mem_rd   = 1'b1;
            o_mem_addr = i_if_addr;
        end else if (ls_pick) begin
            // A store masks a simultaneous (illegal) load.
            o_mem_wr     = i_ls_wr;
            o_mem_rd     = i_ls_rd & ~i_ls_wr;
            o_mem_addr   = i_ls_addr;
            o_mem_wrdata = i_ls_wrdata;
        end
    end

    assign accept           = (if_pick | ls_pick) & ~i_mem_waitrequest;
    assign rd_accept        = accept & o_mem_rd;
    assign o_if_waitrequest = ~(if_pick & accept);
    assign o_ls_waitrequest = ~(ls_pick & accept);

    always_comb begin
        streak_d = streak_q;
        if (!i_if_rd || (if_pick && accept)) begin
            streak_d = '0;
        end else if (ls_pick && accept && streak_q < STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    assign tag_in = '{valid: rd_accept, owner: (ls_pick ? OWN_LS : OWN_IF)};

    rd_tag_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_rd_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .tag_in (tag_in),
        .tag_out(tag_out)
    );

    assign o_if_rddatavalid = tag_out.valid && (tag_out.owner == OWN_IF);
    assign o_ls_rddatavalid = tag_out.valid && (tag_out.owner == OWN_LS);
    assign o_if_rddata      = o_if_rddatavalid ? i_mem_rddata : if_data_q;
    assign o_ls_rddata      = o_ls_rddatavalid ? i_mem_rddata : ls_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_data_q <= '0;
            ls_data_q <= '0;
        end else begin
            if (o_if_rddatavalid) if_data_q <= i_mem_rddata;
            if (o_ls_rddatavalid) ls_data_q <= i_mem_rddata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (read latency 1 and 3) share one stimulus stream and are checked every cycle
// against a transaction-level model of arbitration, locking, streak and read returns.
module tb_mem_port_arbiter;

    localparam int unsigned LAT0       = 1;
    localparam int unsigned LAT1       = 3;
    localparam int unsigned MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_rd, ls_rd, ls_wr, mem_wait;
    logic [15:0] if_addr, ls_addr, ls_wrdata, mem_rddata;
    logic [1:0]  if_wait, ls_wait, mem_rd, mem_wr, if_valid, ls_valid;
    logic [15:0] mem_addr [2];
    logic [15:0] mem_wrdata [2];
    logic [15:0] if_rddata [2];
    logic [15:0] ls_rddata [2];

    int tests = 0;
    int fails = 0;

    // Model: lock 0=none 1=fetch 2=ldst; returns are scheduled by cycle number.
    int          lock, streak, cyc;
    bit          ret_v [2][8];
    bit          ret_ls [2][8];
    logic [15:0] held [2][2];
    bit          last_acc_if, last_acc_ls;

    int          gown_q [$];
    logic [15:0] gaddr_q [$];
    int          gcyc_q [$];
    logic [16:0] ret0_q [$];
    logic [16:0] ret1_q [$];
    int          t3_exp [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W         (16),
            .DATA_W         (16),
            .READ_LATENCY   (g == 0 ? LAT0 : LAT1),
            .MAX_LDST_STREAK(MAX_STREAK)
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .i_if_rd          (if_rd),
            .i_if_addr        (if_addr),
            .o_if_waitrequest (if_wait[g]),
            .o_if_rddata      (if_rddata[g]),
            .o_if_rddatavalid (if_valid[g]),
            .i_ls_rd          (ls_rd),
            .i_ls_wr          (ls_wr),
            .i_ls_addr        (ls_addr),
            .i_ls_wrdata      (ls_wrdata),
            .o_ls_waitrequest (ls_wait[g]),
            .o_ls_rddata      (ls_rddata[g]),
            .o_ls_rddatavalid (ls_valid[g]),
            .o_mem_addr       (mem_addr[g]),
            .o_mem_rd         (mem_rd[g]),
            .o_mem_wr         (mem_wr[g]),
            .o_mem_wrdata     (mem_wrdata[g]),
            .i_mem_waitrequest(mem_wait),
            .i_mem_rddata     (mem_rddata)
        );
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at time %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        int          win, slot, s;
        bit          acc, mrd, mwr, v_if, v_ls;
        @(negedge clk);
        assert (!(ls_rd && ls_wr)) else $error("illegal simultaneous load and store request");
        win  = 0;
        acc  = 1'b0;
        mrd  = 1'b0;
        mwr  = 1'b0;
        slot = cyc % 8;
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                chk("rst_ctrl", {if_wait[d], ls_wait[d], mem_rd[d], mem_wr[d], if_valid[d],
                                 ls_valid[d]}, 6'b110000);
                chk("rst_mem_addr", mem_addr[d], 0);
                chk("rst_mem_wrdata", mem_wrdata[d], 0);
                chk("rst_if_rddata", if_rddata[d], 0);
                chk("rst_ls_rddata", ls_rddata[d], 0);
            end
        end else begin
            win = lock;
            if (win == 0) begin
                if (if_rd && (!(ls_rd || ls_wr) || streak == MAX_STREAK)) win = 1;
                else if (ls_rd || ls_wr) win = 2;
            end
            mrd = (win == 1) || (win == 2 && ls_rd && !ls_wr);
            mwr = (win == 2) && ls_wr;
            acc = (win != 0) && !mem_wait;
            for (int d = 0; d < 2; d++) begin
                v_if = ret_v[d][slot] && !ret_ls[d][slot];
                v_ls = ret_v[d][slot] && ret_ls[d][slot];
                chk("mem_ctrl", {mem_rd[d], mem_wr[d], if_wait[d], ls_wait[d]},
                    {mrd, mwr, !(acc && win == 1), !(acc && win == 2)});
                if (mrd || mwr) chk("mem_addr", mem_addr[d], (win == 1) ? if_addr : ls_addr);
                if (mwr) chk("mem_wrdata", mem_wrdata[d], ls_wrdata);
                chk("rd_valid", {if_valid[d], ls_valid[d]}, {v_if, v_ls});
                chk("if_rddata", if_rddata[d], v_if ? mem_rddata : held[d][0]);
                chk("ls_rddata", ls_rddata[d], v_ls ? mem_rddata : held[d][1]);
            end
            if ((mem_rd[0] || mem_wr[0]) && !mem_wait) begin
                gown_q.push_back(!if_wait[0] ? 1 : (!ls_wait[0] ? 2 : 0));
                gaddr_q.push_back(mem_addr[0]);
                gcyc_q.push_back(cyc);
            end
            if (if_valid[0]) ret0_q.push_back({1'b0, if_rddata[0]});
            if (ls_valid[0]) ret0_q.push_back({1'b1, ls_rddata[0]});
            if (if_valid[1]) ret1_q.push_back({1'b0, if_rddata[1]});
            if (ls_valid[1]) ret1_q.push_back({1'b1, ls_rddata[1]});
        end
        last_acc_if = acc && win == 1;
        last_acc_ls = acc && win == 2;
        @(posedge clk);
        if (reset) begin
            lock   = 0;
            streak = 0;
            cyc    = 0;
            for (int d = 0; d < 2; d++) begin
                held[d][0] = '0;
                held[d][1] = '0;
                for (int k = 0; k < 8; k++) ret_v[d][k] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (ret_v[d][slot]) held[d][ret_ls[d][slot]] = mem_rddata;
                ret_v[d][slot] = 1'b0;
                if (acc && mrd) begin
                    s = (cyc + ((d == 0) ? LAT0 : LAT1)) % 8;
                    ret_v[d][s]  = 1'b1;
                    ret_ls[d][s] = (win == 2);
                end
            end
            lock = (win != 0 && !acc) ? win : 0;
            if (!if_rd || (acc && win == 1)) streak = 0;
            else if (acc && win == 2 && streak < MAX_STREAK) streak++;
            cyc++;
        end
        #1;
    endtask

    task automatic clear_logs();
        gown_q.delete();
        gaddr_q.delete();
        gcyc_q.delete();
        ret0_q.delete();
        ret1_q.delete();
    endtask

    task automatic idle(input int n);
        if_rd    = 1'b0;
        ls_rd    = 1'b0;
        ls_wr    = 1'b0;
        mem_wait = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1;
        if_rd = 1'b0; ls_rd = 1'b0; ls_wr = 1'b0; mem_wait = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wrdata = '0; mem_rddata = '0;
        tick();
        tick();
        reset = 1'b0;
        idle(1);

        // Fetch-only stream
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            if_rd   = 1'b1;
            if_addr = 16'(2 * k);
            mem_rddata = 16'h3000 + 16'(k);
            tick();
        end
        idle(4);
        chk("t1_grants", gown_q.size(), 3);
        for (int k = 0; k < 3 && k < gown_q.size(); k++) begin
            chk("t1_owner", gown_q[k], 1);
            chk("t1_addr", gaddr_q[k], 2 * k);
        end
        chk("t1_returns", ret0_q.size(), 3);
        for (int k = 0; k < ret0_q.size(); k++) chk("t1_ret_owner_if", ret0_q[k][16], 0);

        // Load beats fetch on contention
        clear_logs();
        if_rd = 1'b1; if_addr = 16'h0010; ls_rd = 1'b1; ls_addr = 16'h0100;
        mem_rddata = 16'h1111;
        tick();
        ls_rd = 1'b0; mem_rddata = 16'h5A5A;
        tick();
        if_rd = 1'b0; mem_rddata = 16'h7777;
        idle(4);
        chk("t2_grants", gown_q.size(), 2);
        if (gown_q.size() == 2) begin
            chk("t2_first_ls", {gown_q[0][1:0], gaddr_q[0]}, {2'd2, 16'h0100});
            chk("t2_then_if", {gown_q[1][1:0], gaddr_q[1]}, {2'd1, 16'h0010});
            chk("t2_if_next_cycle", gcyc_q[1] - gcyc_q[0], 1);
        end
        chk("t2_returns", ret0_q.size(), 2);
        if (ret0_q.size() == 2) begin
            chk("t2_ls_data", ret0_q[0], {1'b1, 16'h5A5A});
            chk("t2_if_data", ret0_q[1], {1'b0, 16'h7777});
        end

        // Streak limit forces a fetch every fifth grant
        clear_logs();
        if_rd = 1'b1; if_addr = 16'h0300; ls_rd = 1'b1; ls_addr = 16'h0400;
        repeat (10) tick();
        idle(4);
        chk("t3_grants", gown_q.size(), 10);
        for (int k = 0; k < 10 && k < gown_q.size(); k++) chk("t3_order", gown_q[k], t3_exp[k]);

        // Stalled store stays locked; a fetch arriving mid-stall waits
        clear_logs();
        ls_wr = 1'b1; ls_addr = 16'h0040; ls_wrdata = 16'hBEEF; mem_wait = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                if_rd = 1'b1; if_addr = 16'h0200;
            end
            if (k == 3) mem_wait = 1'b0;
            #1;
            chk("t4_wr_stable", {mem_wr[0], mem_addr[0], mem_wrdata[0]},
                {1'b1, 16'h0040, 16'hBEEF});
            tick();
        end
        ls_wr = 1'b0;
        tick();
        idle(4);
        chk("t4_grants", gown_q.size(), 2);
        if (gown_q.size() == 2) begin
            chk("t4_store", {gown_q[0][1:0], gaddr_q[0]}, {2'd2, 16'h0040});
            chk("t4_fetch", {gown_q[1][1:0], gaddr_q[1]}, {2'd1, 16'h0200});
            chk("t4_fetch_after_accept", gcyc_q[1] - gcyc_q[0], 1);
        end

        // Reset right after an accepted read drops it
        clear_logs();
        if_rd = 1'b1; if_addr = 16'h0500;
        tick();
        if_rd = 1'b0; ls_rd = 1'b1; ls_addr = 16'h0600; reset = 1'b1;
        #1;
        chk("t5_async_ctrl", {if_wait[0], ls_wait[0], mem_rd[0], mem_wr[0], ls_valid[1],
                              if_valid[1]}, 6'b110000);
        chk("t5_async_addr", mem_addr[0], 0);
        tick();
        tick();
        ls_rd = 1'b0; reset = 1'b0;
        idle(5);
        chk("t5_no_return", ret0_q.size() + ret1_q.size(), 0);

        // Alternating owners at full rate
        clear_logs();
        for (int k = 0; k < 12; k++) begin
            if_rd = (k < 8) && (k % 2 == 0);
            ls_rd = (k < 8) && (k % 2 == 1);
            if_addr = 16'h0700 + 16'(k);
            ls_addr = 16'h0800 + 16'(k);
            mem_rddata = 16'h6000 + 16'(k);
            tick();
        end
        chk("t6_returns_l3", ret1_q.size(), 8);
        chk("t6_returns_l1", ret0_q.size(), 8);
        for (int j = 0; j < 8 && j < ret1_q.size() && j < ret0_q.size(); j++) begin
            chk("t6_route_l3", ret1_q[j], {1'(j % 2), 16'h6000 + 16'(j + 3)});
            chk("t6_route_l1", ret0_q[j], {1'(j % 2), 16'h6000 + 16'(j + 1)});
        end
        idle(2);

        // Random traffic with stalls and occasional resets
        for (int n = 0; n < 4000; n++) begin
            int r;
            if (!if_rd || last_acc_if) begin
                if_rd   = 1'($urandom_range(0, 1));
                if_addr = 16'($urandom);
            end
            if (!(ls_rd || ls_wr) || last_acc_ls) begin
                r         = $urandom_range(0, 3);
                ls_rd     = (r == 1) || (r == 3);
                ls_wr     = (r == 2);
                ls_addr   = 16'($urandom);
                ls_wrdata = 16'($urandom);
            end
            mem_wait   = ($urandom_range(0, 3) == 0);
            mem_rddata = 16'($urandom);
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                if_rd = 1'b0; ls_rd = 1'b0; ls_wr = 1'b0;
            end
            tick();
        end
        reset = 1'b0;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
